// File: rtl/ex_operand_stage_if.sv
// Decode-to-execute boundary of the ID/EX operand stage: the instruction offered
// by decode and the operands and control presented to the ALU.
interface ex_operand_stage_if #(parameter int unsigned n = 32);
    logic         in_valid;
    logic         in_ready;
    logic [n-1:0] id_rs1_data;
    logic [n-1:0] id_rs2_data;
    logic [n-1:0] id_imm;
    logic [4:0]   id_rs1_addr;
    logic [4:0]   id_rs2_addr;
    logic [4:0]   id_rd_addr;
    logic [3:0]   id_alu_control;
    logic         id_alu_src;
    logic         id_reg_write;
    logic         id_mem_read;
    logic         out_valid;
    logic         out_ready;
    logic [n-1:0] ex_a;
    logic [n-1:0] ex_b;
    logic [3:0]   ex_alu_control;
    logic [n-1:0] ex_store_data;
    logic [4:0]   ex_rd_addr;
    logic         ex_reg_write;
    logic         ex_mem_read;

    modport master (
        output in_valid, id_rs1_data, id_rs2_data, id_imm, id_rs1_addr, id_rs2_addr,
               id_rd_addr, id_alu_control, id_alu_src, id_reg_write, id_mem_read, out_ready,
        input  in_ready, out_valid, ex_a, ex_b, ex_alu_control, ex_store_data,
               ex_rd_addr, ex_reg_write, ex_mem_read
    );

    modport slave (
        input  in_valid, id_rs1_data, id_rs2_data, id_imm, id_rs1_addr, id_rs2_addr,
               id_rd_addr, id_alu_control, id_alu_src, id_reg_write, id_mem_read, out_ready,
        output in_ready, out_valid, ex_a, ex_b, ex_alu_control, ex_store_data,
               ex_rd_addr, ex_reg_write, ex_mem_read
    );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX stage: holds one decoded instruction, resolves operands with MEM/WB
// forwarding, detects load-use hazards and drives the ALU inputs.
module ex_operand_stage #(
    parameter int unsigned n = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic [4:0]          mem_rd_addr,
    input  logic                mem_reg_write,
    input  logic [n-1:0]        mem_result,
    input  logic [4:0]          wb_rd_addr,
    input  logic                wb_reg_write,
    input  logic [n-1:0]        wb_result,
    ex_operand_stage_if.slave   bus
);
    logic         valid_q;
    logic [n-1:0] rs1_q, rs2_q, imm_q;
    logic [4:0]   rs1_addr_q, rs2_addr_q, rd_addr_q;
    logic [3:0]   alu_control_q;
    logic         alu_src_q, reg_write_q, mem_read_q;

    logic         hazard, in_ready, accept;
    logic [n-1:0] fwd_rs1, fwd_rs2;

    function automatic logic [n-1:0] wb_pick(input logic [4:0] addr, input logic [n-1:0] data);
        return (wb_reg_write && wb_rd_addr != 5'd0 && wb_rd_addr == addr) ? wb_result : data;
    endfunction

    function automatic logic [n-1:0] forward(input logic [4:0] addr, input logic [n-1:0] data);
        if (mem_reg_write && mem_rd_addr != 5'd0 && mem_rd_addr == addr)
            return mem_result;
        return wb_pick(addr, data);
    endfunction

    always_comb begin
        hazard = valid_q && mem_read_q && rd_addr_q != 5'd0 &&
                 (rd_addr_q == bus.id_rs1_addr || rd_addr_q == bus.id_rs2_addr);
        in_ready = !flush && !hazard && (!valid_q || bus.out_ready);
        accept   = bus.in_valid && in_ready;
        fwd_rs1  = forward(rs1_addr_q, rs1_q);
        fwd_rs2  = forward(rs2_addr_q, rs2_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= 1'b0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            imm_q         <= '0;
            rs1_addr_q    <= '0;
            rs2_addr_q    <= '0;
            rd_addr_q     <= '0;
            alu_control_q <= '0;
            alu_src_q     <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
        end else begin
            if (flush)
                valid_q <= 1'b0;
            else if (accept)
                valid_q <= 1'b1;
            else if (bus.out_ready)
                valid_q <= 1'b0;

            if (accept) begin
                rs1_q         <= wb_pick(bus.id_rs1_addr, bus.id_rs1_data);
                rs2_q         <= wb_pick(bus.id_rs2_addr, bus.id_rs2_data);
                imm_q         <= bus.id_imm;
                rs1_addr_q    <= bus.id_rs1_addr;
                rs2_addr_q    <= bus.id_rs2_addr;
                rd_addr_q     <= bus.id_rd_addr;
                alu_control_q <= bus.id_alu_control;
                alu_src_q     <= bus.id_alu_src;
                reg_write_q   <= bus.id_reg_write;
                mem_read_q    <= bus.id_mem_read;
            end else begin
                // A stalled entry keeps absorbing write-backs so it never goes stale.
                rs1_q <= wb_pick(rs1_addr_q, rs1_q);
                rs2_q <= wb_pick(rs2_addr_q, rs2_q);
            end
        end
    end

    always_comb begin
        bus.in_ready       = in_ready;
        bus.out_valid      = valid_q;
        bus.ex_a           = fwd_rs1;
        bus.ex_b           = alu_src_q ? imm_q : fwd_rs2;
        bus.ex_store_data  = fwd_rs2;
        bus.ex_alu_control = alu_control_q;
        bus.ex_rd_addr     = rd_addr_q;
        bus.ex_reg_write   = reg_write_q;
        bus.ex_mem_read    = mem_read_q;
    end
endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: reset, throughput, forwarding,
// load-use bubble, stall refresh and flush.
module tb_ex_operand_stage;
    localparam int unsigned N = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush;
    logic [4:0]   mem_rd_addr, wb_rd_addr;
    logic         mem_reg_write, wb_reg_write;
    logic [N-1:0] mem_result, wb_result;
    int           errors = 0;
    int           checks = 0;

    ex_operand_stage_if #(.n(N)) bus ();

    ex_operand_stage #(.n(N)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        bus.in_valid = 0; bus.out_ready = 1;
        bus.id_rs1_data = '0; bus.id_rs2_data = '0; bus.id_imm = '0;
        bus.id_rs1_addr = '0; bus.id_rs2_addr = '0; bus.id_rd_addr = '0;
        bus.id_alu_control = '0; bus.id_alu_src = 0; bus.id_reg_write = 0; bus.id_mem_read = 0;
        flush = 0; mem_rd_addr = '0; mem_reg_write = 0; mem_result = '0;
        wb_rd_addr = '0; wb_reg_write = 0; wb_result = '0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle();
        repeat (2) @(posedge clk);
        #2;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.ex_a !== 32'h0) begin errors++; $display("FAIL rst_a: got %h expected 0", bus.ex_a); end
        checks++; if (bus.ex_b !== 32'h0) begin errors++; $display("FAIL rst_b: got %h expected 0", bus.ex_b); end
        checks++; if ({bus.ex_alu_control, bus.ex_rd_addr, bus.ex_reg_write, bus.ex_mem_read} !== 11'h0) begin
            errors++; $display("FAIL rst_ctrl: got %h/%h/%b/%b expected 0", bus.ex_alu_control, bus.ex_rd_addr, bus.ex_reg_write, bus.ex_mem_read); end
        @(negedge clk); rst_n = 1;
        tick();
        bus.in_valid = 1; bus.id_rs1_addr = 5'd1; bus.id_rs1_data = 32'd9;
        bus.id_imm = 32'd3; bus.id_alu_src = 1; bus.id_alu_control = 4'h5; bus.out_ready = 0;
        tick();
        bus.in_valid = 0; #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.ex_a !== 32'd9) begin
            errors++; $display("FAIL pre_rst_hold: got valid=%b a=%h expected 1/9", bus.out_valid, bus.ex_a); end
        #1 rst_n = 0; #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.ex_a !== 32'h0 || bus.ex_b !== 32'h0) begin
            errors++; $display("FAIL async_rst_ab: got a=%h b=%h expected 0/0", bus.ex_a, bus.ex_b); end
        @(negedge clk); rst_n = 1; idle();
    endtask

    task automatic test_back_to_back();
        idle(); tick();
        bus.in_valid = 1; bus.id_rs1_addr = 5'd1; bus.id_rs1_data = 32'd5; bus.id_imm = 32'd7;
        bus.id_alu_src = 1; bus.id_alu_control = 4'h2; bus.id_rd_addr = 5'd5; bus.id_reg_write = 1;
        tick();
        bus.id_rs1_addr = 5'd2; bus.id_rs1_data = 32'd10; bus.id_rs2_addr = 5'd3; bus.id_rs2_data = 32'd20;
        bus.id_alu_src = 0; bus.id_alu_control = 4'h6; bus.id_rd_addr = 5'd6;
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.ex_a !== 32'd5 || bus.ex_b !== 32'd7) begin
            errors++; $display("FAIL b2b_first: got v=%b a=%h b=%h expected 1/5/7", bus.out_valid, bus.ex_a, bus.ex_b); end
        checks++; if (bus.ex_alu_control !== 4'h2 || bus.ex_rd_addr !== 5'd5 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_first_ctrl: got op=%h rd=%h rdy=%b expected 2/5/1", bus.ex_alu_control, bus.ex_rd_addr, bus.in_ready); end
        tick();
        bus.in_valid = 0; #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.ex_a !== 32'd10 || bus.ex_b !== 32'd20 || bus.ex_store_data !== 32'd20) begin
            errors++; $display("FAIL b2b_second: got v=%b a=%h b=%h sd=%h expected 1/a/14/14", bus.out_valid, bus.ex_a, bus.ex_b, bus.ex_store_data); end
        checks++; if (bus.ex_alu_control !== 4'h6) begin errors++; $display("FAIL b2b_second_op: got %h expected 6", bus.ex_alu_control); end
        tick(); #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", bus.out_valid); end
        idle();
    endtask

    task automatic test_forward_priority();
        idle(); tick();
        bus.in_valid = 1; bus.id_rs1_addr = 5'd3; bus.id_rs1_data = 32'd1;
        bus.id_rs2_addr = 5'd7; bus.id_rs2_data = 32'h55; bus.out_ready = 0;
        tick();
        bus.in_valid = 0; #1;
        checks++; if (bus.ex_a !== 32'd1) begin errors++; $display("FAIL fwd_none: got %h expected 1", bus.ex_a); end
        mem_rd_addr = 5'd3; mem_reg_write = 1; mem_result = 32'hAA;
        wb_rd_addr = 5'd3; wb_reg_write = 1; wb_result = 32'hBB; #1;
        checks++; if (bus.ex_a !== 32'hAA) begin errors++; $display("FAIL fwd_mem_first: got %h expected aa", bus.ex_a); end
        checks++; if (bus.ex_b !== 32'h55) begin errors++; $display("FAIL fwd_unmatched_b: got %h expected 55", bus.ex_b); end
        mem_reg_write = 0; #1;
        checks++; if (bus.ex_a !== 32'hBB) begin errors++; $display("FAIL fwd_wb: got %h expected bb", bus.ex_a); end
        idle();
        bus.out_ready = 1; bus.in_valid = 1; bus.id_rs1_addr = 5'd0; bus.id_rs1_data = 32'h77;
        mem_rd_addr = 5'd0; mem_reg_write = 1; mem_result = 32'hAA;
        wb_rd_addr = 5'd0; wb_reg_write = 1; wb_result = 32'hBB;
        tick();
        bus.in_valid = 0; #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.ex_a !== 32'h77) begin
            errors++; $display("FAIL fwd_x0: got v=%b a=%h expected 1/77", bus.out_valid, bus.ex_a); end
        idle(); tick();
    endtask

    task automatic test_load_use();
        idle(); tick();
        bus.in_valid = 1; bus.id_rs1_addr = 5'd1; bus.id_rs1_data = 32'd100; bus.id_imm = 32'd8;
        bus.id_alu_src = 1; bus.id_rd_addr = 5'd4; bus.id_mem_read = 1; bus.id_reg_write = 1;
        tick();
        bus.id_rs1_addr = 5'd2; bus.id_rs1_data = 32'd2; bus.id_rs2_addr = 5'd4; bus.id_rs2_data = 32'hDEAD;
        bus.id_alu_src = 0; bus.id_rd_addr = 5'd9; bus.id_mem_read = 0; #1;
        checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL lu_stall: got rdy=%b v=%b expected 0/1", bus.in_ready, bus.out_valid); end
        tick(); #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL lu_bubble: got v=%b rdy=%b expected 0/1", bus.out_valid, bus.in_ready); end
        tick();
        bus.in_valid = 0; wb_rd_addr = 5'd4; wb_reg_write = 1; wb_result = 32'hCAFE; #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.ex_rd_addr !== 5'd9 || bus.ex_a !== 32'd2 || bus.ex_b !== 32'hCAFE) begin
            errors++; $display("FAIL lu_dependent: got v=%b rd=%h a=%h b=%h expected 1/9/2/cafe", bus.out_valid, bus.ex_rd_addr, bus.ex_a, bus.ex_b); end
        idle(); tick();
    endtask

    task automatic test_stall_refresh();
        idle(); tick();
        bus.in_valid = 1; bus.id_rs1_addr = 5'd1; bus.id_rs1_data = 32'h10; bus.id_rs2_addr = 5'd6;
        bus.id_rs2_data = 32'h0; bus.id_imm = 32'd4; bus.id_alu_src = 1; bus.out_ready = 0;
        tick();
        bus.in_valid = 0; wb_rd_addr = 5'd6; wb_reg_write = 1; wb_result = 32'h1234; #1;
        checks++; if (bus.ex_store_data !== 32'h1234) begin errors++; $display("FAIL refresh_fwd: got %h expected 1234", bus.ex_store_data); end
        tick();
        wb_reg_write = 0; wb_result = 32'h0; #1;
        checks++; if (bus.ex_store_data !== 32'h1234 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL refresh_held: got sd=%h v=%b expected 1234/1", bus.ex_store_data, bus.out_valid); end
        tick();
        bus.out_ready = 1; #1;
        checks++; if (bus.ex_store_data !== 32'h1234 || bus.ex_a !== 32'h10 || bus.ex_b !== 32'd4) begin
            errors++; $display("FAIL refresh_release: got sd=%h a=%h b=%h expected 1234/10/4", bus.ex_store_data, bus.ex_a, bus.ex_b); end
        tick(); #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL refresh_drain: got %b expected 0", bus.out_valid); end
        idle();
    endtask

    task automatic test_flush();
        idle(); tick();
        bus.in_valid = 1; bus.id_rs1_addr = 5'd1; bus.id_rs1_data = 32'h99; flush = 1; #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", bus.in_ready); end
        tick();
        flush = 0; bus.id_rs1_data = 32'h42; #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_kill: got v=%b rdy=%b expected 0/1", bus.out_valid, bus.in_ready); end
        tick();
        bus.in_valid = 0; #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.ex_a !== 32'h42) begin
            errors++; $display("FAIL flush_next: got v=%b a=%h expected 1/42", bus.out_valid, bus.ex_a); end
        bus.in_valid = 1; bus.id_rs1_data = 32'h43; flush = 1;
        tick();
        bus.in_valid = 0; flush = 0; #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_transfer: got %b expected 0", bus.out_valid); end
        idle();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_forward_priority();
        test_load_use();
        test_stall_refresh();
        test_flush();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline stage that sits directly upstream of the n-bit ALU. It latches one decoded instruction, resolves its source operands with MEM/WB forwarding, and drives the ALU's A, B and alu_control inputs. It also carries the destination/control bits forward to the EX/MEM stage. The stage owns load-use hazard detection and the valid/ready handshake between decode and execute.

## Interface
- n, 32, datapath width; must match the ALU's n
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  stage accepts this cycle
- id_rs1_data, id_rs2_data  in  n  register-file read data
- id_imm  in  n  sign-extended immediate
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  5  register indices
- id_alu_control  in  4  ALU opcode, passed through unchanged
- id_alu_src  in  1  1: B = immediate, 0: B = rs2 operand
- id_reg_write, id_mem_read  in  1  control bits
- flush  in  1  synchronous kill (branch taken)
- mem_rd_addr, mem_reg_write, mem_result  in  5/1/n  EX/MEM forwarding source
- wb_rd_addr, wb_reg_write, wb_result  in  5/1/n  MEM/WB forwarding source
- out_valid  out  1  held instruction valid
- out_ready  in  1  EX/MEM consumes this cycle
- ex_a, ex_b  out  n  ALU operands
- ex_alu_control  out  4  to ALU
- ex_store_data  out  n  forwarded rs2, for stores
- ex_rd_addr  out  5; ex_reg_write, ex_mem_read  out  1

## Operation
- Stage holds one entry: valid, rs1/rs2 values, imm, rs1/rs2/rd addresses, alu_control, alu_src, reg_write, mem_read.
- Handshake: transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
- hazard = out_valid && ex_mem_read && ex_rd_addr != 0 && (ex_rd_addr == id_rs1_addr || ex_rd_addr == id_rs2_addr).
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- Next out_valid:
  - 0 if flush.
  - Otherwise 1 on accept.
  - Otherwise 0 if out_ready.
  - Otherwise unchanged.
  - Hazard with out_ready inserts exactly one bubble.
- Load capture: each stored rs value takes wb_result when wb_reg_write && wb_rd_addr != 0 && wb_rd_addr matches its id address. Otherwise it takes id data. This covers the same-cycle register-file write.
- Hold refresh: while holding without accept, each stored rs value takes wb_result under the same match rule against the stored address. This prevents stale operands after a downstream stall.
- Forwarding is combinational from stored state. For each operand, the mux priority is:
  - MEM, when mem_reg_write, mem_rd_addr != 0, and address matches.
  - Else WB, under the same rule.
  - Else the stored value.
  - Register x0 is never forwarded.
- ex_a = forwarded rs1. ex_store_data = forwarded rs2. ex_b = imm if alu_src, else forwarded rs2.
- Outputs are driven from stored fields even when out_valid = 0. Consumers qualify them with out_valid.

## Timing
- Reset (async, asserted): out_valid = 0 and every stored field = 0. ex_a, ex_b, ex_store_data, ex_alu_control, ex_rd_addr, ex_reg_write and ex_mem_read all read 0 (absent forwarding matches, which cannot hit x0). Release is synchronous to clk.
- Latency: accept at edge k gives out_valid = 1 after edge k, so ex_* are valid in cycle k+1.
- Throughput: one instruction per cycle when out_ready is held at 1 and there is no hazard.
- in_ready is combinational from state, flush, id addresses and out_ready.
- Flush together with in_valid: input is not accepted and out_valid = 0 next cycle.
- Flush together with a downstream transfer: the transfer completes and out_valid = 0 next cycle.
- Reset mid-operation: the held entry is discarded immediately and out_valid drops asynchronously.

## Test plan
- Reset then idle: rst_n = 0 with out_valid previously 1 -> out_valid = 0 and ex_a = ex_b = 0 before the next clk edge.
- Back-to-back: issue an ADD with rs1 = x1 = 5, imm = 7, alu_src = 1, then a second instruction next cycle, out_ready = 1 -> ex_a = 5 and ex_b = 7 in cycle k+1; second instruction on the next cycle with no gap.
- Forward priority: stored rs1 = x3 = 1; mem writes x3 = 0xAA and wb writes x3 = 0xBB -> ex_a = 0xAA. With mem_reg_write = 0 -> ex_a = 0xBB. With rs1 = x0 and matching x0 writes -> ex_a = stored value.
- Load-use: held LW with rd = x4, incoming rs2 = x4, out_ready = 1 -> in_ready = 0 for one cycle, then a bubble (out_valid = 0), then the dependent instruction is accepted.
- Stall refresh: out_ready = 0 for 3 cycles; wb writes stored rs2 = x6 = 0x1234 and then stops forwarding -> ex_store_data = 0x1234 after release.
- Flush: flush = 1 together with in_valid = 1 -> in_ready = 0 and out_valid = 0 on the next cycle; next instruction accepted normally.
